// File: rtl/simple_dualportram_arbiter.sv
// simple_dualportram_arbiter: round-robin sharing of the RAM read/write port between two masters
module simple_dualportram_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 10,
  parameter int WORDS = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_0,
  input  logic             req_1,
  input  logic             we_0,
  input  logic             we_1,
  input  logic [31:0]      address_0,
  input  logic [31:0]      address_1,
  input  logic [WIDTH-1:0] din_0,
  input  logic [WIDTH-1:0] din_1,
  output logic             ack_0,
  output logic             ack_1,
  output logic             err_0,
  output logic             err_1,
  output logic [WIDTH-1:0] dout_0,
  output logic [WIDTH-1:0] dout_1,
  output logic             rvalid_0,
  output logic             rvalid_1,
  output logic [31:0]      ram_address,
  output logic [WIDTH-1:0] ram_din,
  output logic             ram_we,
  output logic             ram_oe,
  input  logic [WIDTH-1:0] ram_dout,
  input  logic [31:0]      ram_length
);
  logic prio, e0, e1, g0, g1, oob0, oob1, unused_cfg;
  logic [2:0] rd_s1, rd_s2;
  assign unused_cfg = |{DEPTH, WORDS};
  assign e0 = req_0 & ~ack_0;
  assign e1 = req_1 & ~ack_1;
  assign g0 = e0 & (~e1 | ~prio);
  assign g1 = e1 & ~g0;
  assign oob0 = address_0 >= ram_length;
  assign oob1 = address_1 >= ram_length;
  // issue the granted request to the RAM port and rotate priority away from the winner
  always_ff @(posedge clk) begin
    if (reset) begin
      prio <= 1'b0;
      ack_0 <= 1'b0;
      ack_1 <= 1'b0;
      err_0 <= 1'b0;
      err_1 <= 1'b0;
      ram_we <= 1'b0;
      ram_oe <= 1'b0;
      ram_address <= '0;
      ram_din <= '0;
    end else begin
      ack_0 <= g0;
      ack_1 <= g1;
      err_0 <= g0 & oob0;
      err_1 <= g1 & oob1;
      ram_we <= g0 ? we_0 & ~oob0 : g1 & we_1 & ~oob1;
      ram_oe <= g0 ? ~we_0 & ~oob0 : g1 & ~we_1 & ~oob1;
      if (g0 | g1) begin
        prio <= g0;
        ram_address <= g0 ? address_0 : address_1;
        ram_din <= g0 ? din_0 : din_1;
      end
    end
  end
  // carry {valid, id, oob} of each read grant alongside the RAM's one-cycle read latency
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_s1 <= '0;
      rd_s2 <= '0;
    end else begin
      rd_s1 <= {(g0 & ~we_0) | (g1 & ~we_1), g1, g0 ? oob0 : oob1};
      rd_s2 <= rd_s1;
    end
  end
  // return read data to the owning master; out-of-bounds reads return zero
  always_ff @(posedge clk) begin
    if (reset) begin
      rvalid_0 <= 1'b0;
      rvalid_1 <= 1'b0;
      dout_0 <= '0;
      dout_1 <= '0;
    end else begin
      rvalid_0 <= rd_s2[2] & ~rd_s2[1];
      rvalid_1 <= rd_s2[2] & rd_s2[1];
      if (rd_s2[2] & ~rd_s2[1]) dout_0 <= rd_s2[0] ? '0 : ram_dout;
      if (rd_s2[2] & rd_s2[1]) dout_1 <= rd_s2[0] ? '0 : ram_dout;
    end
  end
endmodule

// File: tb/tb_simple_dualportram_arbiter.sv
// tb_simple_dualportram_arbiter: vector table plus read-data scoreboard for the arbiter
module tb_simple_dualportram_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic req_0, req_1, we_0, we_1;
  logic [31:0] address_0, address_1, din_0, din_1;
  logic ack_0, ack_1, err_0, err_1, rvalid_0, rvalid_1;
  logic [31:0] dout_0, dout_1, ram_address, ram_din, ram_dout, ram_length;
  logic ram_we, ram_oe;
  logic [31:0] mem [0:1023];
  logic [31:0] model [0:1023];
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic r0, w0;
    logic [31:0] a0, d0;
    logic r1, w1;
    logic [31:0] a1, d1;
    logic k0, k1, e0, e1, we, oe;
    logic [31:0] ra;
  } vec_t;
  typedef struct {
    logic id;
    logic [31:0] d;
  } rd_t;
  vec_t tbl [12];
  rd_t sb [$];

  simple_dualportram_arbiter #(.WIDTH(32), .DEPTH(10), .WORDS(1024)) dut (
    .clk(clk), .reset(reset),
    .req_0(req_0), .req_1(req_1), .we_0(we_0), .we_1(we_1),
    .address_0(address_0), .address_1(address_1), .din_0(din_0), .din_1(din_1),
    .ack_0(ack_0), .ack_1(ack_1), .err_0(err_0), .err_1(err_1),
    .dout_0(dout_0), .dout_1(dout_1), .rvalid_0(rvalid_0), .rvalid_1(rvalid_1),
    .ram_address(ram_address), .ram_din(ram_din), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_dout(ram_dout), .ram_length(ram_length)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we && ram_address < 1024) mem[ram_address[9:0]] <= ram_din;
    if (ram_oe) ram_dout <= mem[ram_address[9:0]];
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  task automatic step();
    rd_t e;
    @(posedge clk);
    #1;
    if (rvalid_0 || rvalid_1) begin
      if (sb.size() == 0) chk("rv_unexpected", 32'({rvalid_1, rvalid_0}), 32'd0);
      else begin
        e = sb.pop_front();
        chk("rv_id", 32'({rvalid_1, rvalid_0}), e.id ? 32'd2 : 32'd1);
        chk("rv_data", e.id ? dout_1 : dout_0, e.d);
      end
    end
  endtask

  task automatic idle();
    req_0 = 1'b0;
    req_1 = 1'b0;
  endtask

  task automatic push(input logic id, input logic [31:0] d);
    rd_t e;
    e.id = id;
    e.d = d;
    sb.push_back(e);
  endtask

  task automatic chk_all_zero(input string n);
    chk({n, "_ack"}, 32'({ack_1, ack_0}), 32'd0);
    chk({n, "_err"}, 32'({err_1, err_0}), 32'd0);
    chk({n, "_rvalid"}, 32'({rvalid_1, rvalid_0}), 32'd0);
    chk({n, "_dout0"}, dout_0, 32'd0);
    chk({n, "_dout1"}, dout_1, 32'd0);
    chk({n, "_raddr"}, ram_address, 32'd0);
    chk({n, "_rdin"}, ram_din, 32'd0);
    chk({n, "_rweoe"}, 32'({ram_we, ram_oe}), 32'd0);
  endtask

  initial begin
    logic w, wr, oob;
    logic [31:0] a, d;
    for (int i = 0; i < 1024; i++) model[i] = 32'd0;
    ram_length = 32'd1024;
    reset = 1'b1;
    idle();
    we_0 = 1'b0; we_1 = 1'b0;
    address_0 = 32'd0; address_1 = 32'd0; din_0 = 32'd0; din_1 = 32'd0;
    repeat (3) step();
    chk_all_zero("reset");
    reset = 1'b0;
    step();

    req_0 = 1'b1; we_0 = 1'b1; address_0 = 32'd5; din_0 = 32'hDEADBEEF;
    model[5] = 32'hDEADBEEF;
    step();
    chk("sw_ack0", 32'(ack_0), 32'd1);
    chk("sw_we", 32'({ram_we, ram_oe}), 32'd2);
    chk("sw_addr", ram_address, 32'd5);
    chk("sw_din", ram_din, 32'hDEADBEEF);
    idle();
    step();
    req_0 = 1'b1; we_0 = 1'b0; address_0 = 32'd5;
    push(1'b0, 32'hDEADBEEF);
    step();
    chk("sr_ack0", 32'(ack_0), 32'd1);
    chk("sr_oe", 32'({ram_we, ram_oe}), 32'd1);
    idle();
    step();
    chk("sr_c2_rvalid", 32'(rvalid_0), 32'd0);
    step();
    chk("sr_c3_rvalid", 32'(rvalid_0), 32'd1);
    step();
    chk("sr_hold_rvalid", 32'(rvalid_0), 32'd0);
    chk("sr_hold_dout", dout_0, 32'hDEADBEEF);

    tbl[0]  = '{1'b1, 1'b1, 32'd1, 32'h11111111, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1};
    tbl[1]  = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd2, 32'h22222222, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'd2};
    tbl[2]  = '{1'b1, 1'b0, 32'd5, 32'd0, 1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5};
    tbl[3]  = '{1'b1, 1'b0, 32'd1, 32'd0, 1'b1, 1'b0, 32'd2, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2};
    tbl[4]  = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b1, 32'd1024, 32'hBAD0BAD0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd1024};
    tbl[5]  = '{1'b1, 1'b0, 32'd3000, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd3000};
    tbl[6]  = '{1'b1, 1'b1, 32'd1023, 32'hCAFEF00D, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd1023};
    tbl[7]  = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 32'd1023, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1023};
    tbl[8]  = '{1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1023};
    tbl[9]  = '{1'b1, 1'b1, 32'd8, 32'hA5A5A5A5, 1'b1, 1'b1, 32'd9, 32'h5A5A5A5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd8};
    tbl[10] = '{1'b1, 1'b0, 32'd8, 32'd0, 1'b1, 1'b0, 32'd2000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd2000};
    tbl[11] = '{1'b1, 1'b0, 32'd8, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd8};
    for (int i = 0; i < 12; i++) begin
      req_0 = tbl[i].r0; we_0 = tbl[i].w0; address_0 = tbl[i].a0; din_0 = tbl[i].d0;
      req_1 = tbl[i].r1; we_1 = tbl[i].w1; address_1 = tbl[i].a1; din_1 = tbl[i].d1;
      w = tbl[i].k1;
      wr = w ? tbl[i].w1 : tbl[i].w0;
      a = w ? tbl[i].a1 : tbl[i].a0;
      d = w ? tbl[i].d1 : tbl[i].d0;
      oob = a >= 32'd1024;
      if (tbl[i].k0 || tbl[i].k1) begin
        if (!wr) push(w, oob ? 32'd0 : model[a[9:0]]);
        else if (!oob) model[a[9:0]] = d;
      end
      step();
      chk($sformatf("v%0d_ack", i), 32'({ack_1, ack_0}), 32'({tbl[i].k1, tbl[i].k0}));
      chk($sformatf("v%0d_err", i), 32'({err_1, err_0}), 32'({tbl[i].e1, tbl[i].e0}));
      chk($sformatf("v%0d_weoe", i), 32'({ram_we, ram_oe}), 32'({tbl[i].we, tbl[i].oe}));
      chk($sformatf("v%0d_raddr", i), ram_address, tbl[i].ra);
      if (tbl[i].k0 || tbl[i].k1) chk($sformatf("v%0d_rdin", i), ram_din, d);
      idle();
      step();
      chk($sformatf("v%0d_withdraw", i), 32'({ack_1, ack_0}), 32'd0);
    end
    repeat (3) step();
    chk("tbl_drain", 32'(sb.size()), 32'd0);

    req_0 = 1'b1; we_0 = 1'b0; address_0 = 32'd5;
    step();
    chk("mid_ack0", 32'(ack_0), 32'd1);
    idle();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mid_rst%0d_rvalid", i), 32'({rvalid_1, rvalid_0}), 32'd0);
    end
    chk_all_zero("mid_rst");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post_rst%0d_rvalid", i), 32'({rvalid_1, rvalid_0}), 32'd0);
    end

    req_0 = 1'b1; we_0 = 1'b0; address_0 = 32'd1;
    req_1 = 1'b1; we_1 = 1'b0; address_1 = 32'd2;
    for (int i = 0; i < 8; i++) begin
      push(i[0], i[0] ? model[2] : model[1]);
      step();
      chk($sformatf("cont%0d_ack", i), 32'({ack_1, ack_0}), i[0] ? 32'd2 : 32'd1);
      chk($sformatf("cont%0d_addr", i), ram_address, i[0] ? 32'd2 : 32'd1);
    end
    idle();
    repeat (3) step();

    req_1 = 1'b1; we_1 = 1'b0; address_1 = 32'd2;
    push(1'b1, model[2]);
    step();
    chk("rot_m1_ack", 32'({ack_1, ack_0}), 32'd2);
    idle();
    step();
    req_0 = 1'b1; we_0 = 1'b0; address_0 = 32'd1;
    req_1 = 1'b1; we_1 = 1'b0; address_1 = 32'd5;
    push(1'b0, model[1]);
    step();
    chk("rot_both_ack", 32'({ack_1, ack_0}), 32'd1);
    req_0 = 1'b0;
    push(1'b1, model[5]);
    step();
    chk("rot_m1_second_ack", 32'({ack_1, ack_0}), 32'd2);
    chk("rot_m1_second_addr", ram_address, 32'd5);
    idle();
    repeat (3) step();

    req_0 = 1'b1; we_0 = 1'b1; address_0 = 32'd7; din_0 = 32'h12345678;
    req_1 = 1'b1; we_1 = 1'b0; address_1 = 32'd7;
    model[7] = 32'h12345678;
    step();
    chk("coh_wr_ack", 32'({ack_1, ack_0}), 32'd1);
    chk("coh_wr_we", 32'({ram_we, ram_oe}), 32'd2);
    req_0 = 1'b0;
    push(1'b1, 32'h12345678);
    step();
    chk("coh_rd_ack", 32'({ack_1, ack_0}), 32'd2);
    chk("coh_rd_oe", 32'({ram_we, ram_oe}), 32'd1);
    idle();
    repeat (4) step();
    chk("final_drain", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
